mem_stage_lsu: RTL and testbench

- Load/store unit for the MEM stage of the 5-stage pipelined ARM core, directly downstream of the datapath's EX/MEM register (consumes ALUOutM, WriteDataM, MemWriteM, MemtoRegM).
- Drives a req/ready data-memory port, performs byte/word lane handling and produces ReadDataM for the MEM/WB register.
- Raises StallM to the hazard unit while an access is outstanding; bounds memory latency with a timeout counter.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_lane.sv | 36 +++
 rtl/mem_stage_lsu.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_t;

    localparam logic [3:0]  BE_WORD            = 4'hF;
    localparam logic [3:0]  BE_BYTE0           = 4'b0001;
    localparam logic [31:0] FAULT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store replication / byte enables and load lane extraction.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic        st_byte_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic        ld_byte_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_rdata_o
);

    // Store side: replicate the low byte to every lane so any lane can be enabled.
    always_comb begin
        if (st_byte_i) begin
            st_be_o    = BE_BYTE0 << st_offset_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
        end else begin
            st_be_o    = BE_WORD;
            st_wdata_o = st_wdata_i;
        end
    end

    // Load side: pick the addressed byte and zero-extend, or pass the full word.
    always_comb begin
        if (ld_byte_i) begin
            ld_rdata_o = {24'h0, ld_rdata_i[{ld_offset_i, 3'b000} +: 8]};
        end else begin
            ld_rdata_o = ld_rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding req/ready access, lane handling,
// pipeline stall generation and a bounded wait for the memory.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FAULT_DATA     = FAULT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        ByteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic        byte_q, byte_d;
    logic        load_q, load_d;
    logic        fault_q, fault_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] lane_rdata;

    assign access     = MemWriteM | MemtoRegM;
    assign misaligned = !ByteM && (ALUOutM[1:0] != 2'b00);

    lsu_lane u_lane (
        .st_byte_i   (ByteM),
        .st_offset_i (ALUOutM[1:0]),
        .st_wdata_i  (WriteDataM),
        .st_wdata_o  (lane_wdata),
        .st_be_o     (lane_be),
        .ld_byte_i   (byte_q),
        .ld_offset_i (off_q),
        .ld_rdata_i  (dmem_rdata),
        .ld_rdata_o  (lane_rdata)
    );

    // Next-state: accept an access in IDLE, wait for ready or timeout in REQ, retire in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        byte_d  = byte_q;
        load_d  = load_q;
        fault_d = fault_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        // No bus cycle; only a load has a destination for the fault value.
                        fault_d = 1'b1;
                        if (!MemWriteM) rdata_d = FAULT_DATA;
                        state_d = DONE;
                    end else begin
                        off_d   = ALUOutM[1:0];
                        byte_d  = ByteM;
                        load_d  = !MemWriteM;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUOutM[31:2], 2'b00};
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                    if (load_q) rdata_d = lane_rdata;
                    state_d = DONE;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                    fault_d = 1'b1;
                    if (load_q) rdata_d = FAULT_DATA;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            off_q   <= 2'b00;
            byte_q  <= 1'b0;
            load_q  <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            byte_q  <= byte_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall covers the detect cycle and the wait; DONE lets the pipeline advance.
    always_comb begin
        StallM = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE:    StallM = access;
                REQ:     StallM = 1'b1;
                default: StallM = 1'b0;
            endcase
        end
    end

    assign FaultM     = (state_q == DONE) && fault_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign ReadDataM  = rdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic        ByteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;

    int n_cmp;
    int n_bad;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (4),
        .FAULT_DATA     (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        ByteM      = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        reset = 1'b1;
        // Access requested while in reset must not stall.
        MemtoRegM = 1'b1;
        @(negedge clk);
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_be", {28'b0, dmem_be}, 32'h0);
        edge_drive();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("nonmem_stall", {31'b0, StallM}, 32'd0);

        // LDR word 0x100, ready on the second REQ cycle.
        edge_drive();
        MemtoRegM = 1'b1;
        ALUOutM   = 32'h100;
        @(negedge clk);
        chk("ldr_c0_stall", {31'b0, StallM}, 32'd1);
        chk("ldr_c0_req", {31'b0, dmem_req}, 32'd0);
        edge_drive();
        @(negedge clk);
        chk("ldr_c1_req", {31'b0, dmem_req}, 32'd1);
        chk("ldr_addr", dmem_addr, 32'h100);
        chk("ldr_be", {28'b0, dmem_be}, 32'hF);
        chk("ldr_we", {31'b0, dmem_we}, 32'd0);
        chk("ldr_c1_stall", {31'b0, StallM}, 32'd1);
        edge_drive();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("ldr_c2_stall", {31'b0, StallM}, 32'd1);
        edge_drive();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("ldr_done_stall", {31'b0, StallM}, 32'd0);
        chk("ldr_rdata", ReadDataM, 32'h1234_5678);
        chk("ldr_fault", {31'b0, FaultM}, 32'd0);
        chk("ldr_done_req", {31'b0, dmem_req}, 32'd0);

        // STRB 0x203; ready held high from the detect cycle (ignored until REQ).
        edge_drive();
        idle_inputs();
        MemWriteM  = 1'b1;
        ByteM      = 1'b1;
        ALUOutM    = 32'h203;
        WriteDataM = 32'hAABB_CCDD;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("strb_c0_stall", {31'b0, StallM}, 32'd1);
        chk("strb_c0_req", {31'b0, dmem_req}, 32'd0);
        edge_drive();
        @(negedge clk);
        chk("strb_req", {31'b0, dmem_req}, 32'd1);
        chk("strb_we", {31'b0, dmem_we}, 32'd1);
        chk("strb_addr", dmem_addr, 32'h200);
        chk("strb_be", {28'b0, dmem_be}, 32'h8);
        chk("strb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        chk("strb_c1_stall", {31'b0, StallM}, 32'd1);
        edge_drive();
        @(negedge clk);
        chk("strb_done_stall", {31'b0, StallM}, 32'd0);
        chk("strb_done_req", {31'b0, dmem_req}, 32'd0);
        chk("strb_done_we", {31'b0, dmem_we}, 32'd0);
        chk("strb_done_be", {28'b0, dmem_be}, 32'h0);
        chk("strb_keep_rdata", ReadDataM, 32'h1234_5678);

        // Misaligned LDR 0x101: no request, fault pulse, fault data.
        edge_drive();
        idle_inputs();
        MemtoRegM = 1'b1;
        ALUOutM   = 32'h101;
        @(negedge clk);
        chk("mis_c0_stall", {31'b0, StallM}, 32'd1);
        chk("mis_c0_req", {31'b0, dmem_req}, 32'd0);
        edge_drive();
        @(negedge clk);
        chk("mis_done_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_fault", {31'b0, FaultM}, 32'd1);
        chk("mis_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("mis_done_stall", {31'b0, StallM}, 32'd0);
        edge_drive();
        idle_inputs();
        @(negedge clk);
        chk("mis_fault_clr", {31'b0, FaultM}, 32'd0);

        // LDRB 0x302, ready immediately: lane 2 of 0x11223344.
        edge_drive();
        MemtoRegM = 1'b1;
        ByteM     = 1'b1;
        ALUOutM   = 32'h302;
        @(negedge clk);
        chk("ldrb_c0_stall", {31'b0, StallM}, 32'd1);
        edge_drive();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("ldrb_be", {28'b0, dmem_be}, 32'h4);
        chk("ldrb_addr", dmem_addr, 32'h300);
        edge_drive();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("ldrb_rdata", ReadDataM, 32'h0000_0022);
        chk("ldrb_fault", {31'b0, FaultM}, 32'd0);

        // LDR 0x400 with no ready: 4 REQ cycles, then abort.
        edge_drive();
        idle_inputs();
        MemtoRegM = 1'b1;
        ALUOutM   = 32'h400;
        @(negedge clk);
        chk("tmo_c0_req", {31'b0, dmem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            edge_drive();
            @(negedge clk);
            chk($sformatf("tmo_req_%0d", i), {31'b0, dmem_req}, 32'd1);
            chk($sformatf("tmo_stall_%0d", i), {31'b0, StallM}, 32'd1);
        end
        edge_drive();
        @(negedge clk);
        chk("tmo_done_req", {31'b0, dmem_req}, 32'd0);
        chk("tmo_fault", {31'b0, FaultM}, 32'd1);
        chk("tmo_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("tmo_done_stall", {31'b0, StallM}, 32'd0);
        edge_drive();
        idle_inputs();
        @(negedge clk);
        chk("tmo_idle_fault", {31'b0, FaultM}, 32'd0);
        chk("tmo_idle_stall", {31'b0, StallM}, 32'd0);

        // STR 0x500 interrupted by reset in its second REQ cycle.
        edge_drive();
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h500;
        WriteDataM = 32'hCAFE_F00D;
        edge_drive();
        @(negedge clk);
        chk("rstm_req1", {31'b0, dmem_req}, 32'd1);
        chk("rstm_wdata", dmem_wdata, 32'hCAFE_F00D);
        edge_drive();
        reset = 1'b1;
        #1;
        chk("rstm_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("rstm_stall_drop", {31'b0, StallM}, 32'd0);
        edge_drive();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rstm_idle_stall", {31'b0, StallM}, 32'd0);
        chk("rstm_idle_rdata", ReadDataM, 32'h0);

        // Follow-up LDR 0x600 completes normally.
        edge_drive();
        MemtoRegM = 1'b1;
        ALUOutM   = 32'h600;
        @(negedge clk);
        chk("post_c0_stall", {31'b0, StallM}, 32'd1);
        edge_drive();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("post_req", {31'b0, dmem_req}, 32'd1);
        chk("post_addr", dmem_addr, 32'h600);
        edge_drive();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("post_rdata", ReadDataM, 32'h0BAD_F00D);
        chk("post_fault", {31'b0, FaultM}, 32'd0);
        edge_drive();
        idle_inputs();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
